// File: rtl/al422_frame_writer.sv
// al422_frame_writer
//   Write-side front end for the AL422 frame FIFO. Takes a byte stream with
//   start-of-frame markers, resets the AL422 write pointer at every frame
//   start and writes exactly FRAME_BYTES bytes per frame through registered
//   WCK, /WE, /WRST and DI pins derived from the system clock.
//
// Ports
//   in_clk, in_rst   system clock, synchronous active-high reset
//   in_data          stream byte (opaque payload)
//   in_valid/in_sof  byte valid / byte is byte 0 of a frame
//   in_ready         registered ready
//   al422_data       AL422 DI bus
//   al422_wclk       AL422 WCK, half of in_clk, 50% duty
//   al422_we_n       AL422 /WE
//   al422_wrst_n     AL422 /WRST
//   frame_done       one-cycle pulse after the last byte of a frame is latched
//   err_short        one-cycle pulse when an SOF aborts an incomplete frame
//   err_drop         one-cycle pulse when a stray non-SOF byte is discarded
//   dbg_state        current FSM state (0 IDLE, 1 WRST, 2 WRITE, 3 DONE)
//
// Handshake: a byte transfers on a rising in_clk edge where in_valid and
// in_ready are both 1. The source holds in_valid, in_sof and in_data stable
// until that edge; in_ready never depends combinationally on the inputs.
module al422_frame_writer #(
    parameter int FRAME_BYTES = 8192,
    parameter int RST_WCK     = 2
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [7:0] al422_data,
    output logic       al422_wclk,
    output logic       al422_we_n,
    output logic       al422_wrst_n,
    output logic       frame_done,
    output logic       err_short,
    output logic       err_drop,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRST  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] FRAME_LAST = 16'(FRAME_BYTES);
    localparam logic [3:0]  RST_RISES  = 4'(RST_WCK);

    state_t      state_q, state_d;
    logic        wclk_q, wclk_d;
    logic        we_n_q, we_n_d;
    logic        wrst_n_q, wrst_n_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic        drop_q, drop_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        accept;

    assign accept = in_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        wclk_d      = ~wclk_q;
        we_n_d      = we_n_q;
        wrst_n_d    = wrst_n_q;
        data_d      = data_q;
        done_d      = 1'b0;
        short_d     = 1'b0;
        drop_d      = 1'b0;
        cnt_d       = cnt_q;
        rst_cnt_d   = rst_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        // wclk_q=1 means this edge is a WCK falling edge (the only edge on
        // which DI and /WE may move); wclk_q=0 means WCK rises on this edge.
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                        rst_cnt_d   = 4'd0;
                        wrst_n_d    = 1'b0;
                        state_d     = S_WRST;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_WRST: begin
                // Count WCK rises seen with /WRST already low; release on
                // the following falling edge so /WRST never moves with a rise.
                if (!wclk_q) begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end else if (rst_cnt_q == RST_RISES) begin
                    wrst_n_d = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q == FRAME_LAST) begin
                    // The last byte is latched by the rise on this edge.
                    if (!wclk_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (wclk_q) begin
                    we_n_d = 1'b1;
                    if (hold_full_q) begin
                        data_d      = hold_q;
                        we_n_d      = 1'b0;
                        hold_full_d = 1'b0;
                        cnt_d       = cnt_q + 16'd1;
                    end else if (accept) begin
                        if (in_sof) begin
                            // Abort: the new SOF byte waits in the hold
                            // register while the pointer is reset again.
                            hold_d      = in_data;
                            hold_full_d = 1'b1;
                            short_d     = 1'b1;
                            rst_cnt_d   = 4'd0;
                            wrst_n_d    = 1'b0;
                            state_d     = S_WRST;
                        end else begin
                            data_d = in_data;
                            we_n_d = 1'b0;
                            cnt_d  = cnt_q + 16'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                // DONE always lasts one cycle with WCK high, so this edge is
                // a falling edge and /WE can be released here.
                we_n_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Accept in WRITE only for cycles where WCK will be high, so the
        // accepted byte is driven on the following falling edge.
        ready_d = (state_d == S_IDLE) ||
                  ((state_d == S_WRITE) && wclk_d && !hold_full_d &&
                   (cnt_d != FRAME_LAST));
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            wclk_q      <= 1'b0;
            we_n_q      <= 1'b1;
            wrst_n_q    <= 1'b1;
            data_q      <= 8'd0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= 16'd0;
            rst_cnt_q   <= 4'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wclk_q      <= wclk_d;
            we_n_q      <= we_n_d;
            wrst_n_q    <= wrst_n_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            short_q     <= short_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign in_ready     = ready_q;
    assign al422_data   = data_q;
    assign al422_wclk   = wclk_q;
    assign al422_we_n   = we_n_q;
    assign al422_wrst_n = wrst_n_q;
    assign frame_done   = done_q;
    assign err_short    = short_q;
    assign err_drop     = drop_q;
    assign dbg_state    = state_q;

endmodule
